spi_operand_fifo: RTL and testbench

SPI_OPERAND_FIFO -- requirements
Module: spi_operand_fifo

---
 rtl/spi_operand_fifo.sv | 144 ++++++++++++++
 tb/tb_spi_operand_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_operand_fifo.sv
// SPI operand FIFO: buffers operand bytes of a write opcode,
// reports status on a status opcode and empties on a flush opcode.
module spi_operand_fifo #(
   parameter logic [7:0] WRITE_OPCODE  = 8'h44,
   parameter logic [7:0] STATUS_OPCODE = 8'h45,
   parameter logic [7:0] FLUSH_OPCODE  = 8'h46,
   parameter int         DEPTH         = 16
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic [7:0]  opcode_in,
   input  logic        opcode_valid_in,
   input  logic [7:0]  operand_in,
   input  logic        operand_valid_in,
   input  logic [31:0] operand_count_in,
   output logic [7:0]  data_out,
   output logic        data_valid_out,
   input  logic        data_ready_in,
   output logic [7:0]  response_out,
   output logic        response_valid_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      STATUS,
      FLUSH
   } state_t;

   state_t        state;
   state_t        state_n;
   logic          opv_q;
   logic          odv_q;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_n;
   logic [PW-1:0] rd_n;
   logic [PW-1:0] level;
   logic          overflow;
   logic [7:0]    mem [DEPTH];

   logic          opcode_rise;
   logic          flush;
   logic          push_req;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          ovf_set;
   logic          valid_n;
   logic [7:0]    head_n;
   logic          resp_n;
   logic [6:0]    lvl_w;
   logic [4:0]    lvl5;
   logic          unused_count;

   // Operand index carries no meaning here; pushes come from edges only.
   assign unused_count = ^operand_count_in;

   assign opcode_rise = opcode_valid_in && !opv_q;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (opcode_rise) begin
               if (opcode_in == WRITE_OPCODE)
                  state_n = WRITE;
               else if (opcode_in == STATUS_OPCODE)
                  state_n = STATUS;
               else if (opcode_in == FLUSH_OPCODE)
                  state_n = FLUSH;
            end
         end
         WRITE, STATUS: begin
            if (!opcode_valid_in)
               state_n = IDLE;
         end
         FLUSH:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      level    = wr_ptr - rd_ptr;
      full     = (level == PW'(DEPTH));
      flush    = (state == FLUSH);
      push_req = (state == WRITE) && operand_valid_in && !odv_q;
      pop      = data_valid_out && data_ready_in && !flush;
      push_ok  = push_req && (!full || pop) && !flush;
      ovf_set  = push_req && full && !pop && !flush;
      wr_n     = wr_ptr + PW'(push_ok);
      rd_n     = rd_ptr + PW'(pop);
      if (flush) begin
         wr_n = '0;
         rd_n = '0;
      end
      valid_n = (wr_n != rd_n);
      // A byte written this edge is not in the array yet; bypass it.
      if (push_ok && (rd_n == wr_ptr))
         head_n = operand_in;
      else
         head_n = mem[rd_n[AW-1:0]];
      lvl_w  = 7'(level);
      lvl5   = (lvl_w > 7'd31) ? 5'd31 : lvl_w[4:0];
      resp_n = (state == STATUS) && (state_n == STATUS);
   end

   // Opcode-valid history resets high so a level held through reset
   // is not mistaken for a fresh edge.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state              <= IDLE;
         opv_q              <= 1'b1;
         odv_q              <= 1'b0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         overflow           <= 1'b0;
         data_valid_out     <= 1'b0;
         data_out           <= 8'h00;
         response_out       <= 8'h00;
         response_valid_out <= 1'b0;
      end else begin
         state              <= state_n;
         opv_q              <= opcode_valid_in;
         odv_q              <= operand_valid_in;
         wr_ptr             <= wr_n;
         rd_ptr             <= rd_n;
         overflow           <= flush ? 1'b0 : (overflow | ovf_set);
         data_valid_out     <= valid_n;
         data_out           <= valid_n ? head_n : 8'h00;
         response_valid_out <= resp_n;
         response_out       <= resp_n ? {overflow, 2'b00, lvl5} : 8'h00;
      end
   end

   always_ff @(posedge clock_in) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= operand_in;
   end

endmodule

// File: tb/tb_spi_operand_fifo.sv
// Scoreboard bench for spi_operand_fifo: expected bytes are queued
// when pushed and compared as the consumer pops them.
module tb_spi_operand_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  opcode;
   logic        opcode_valid;
   logic [7:0]  operand;
   logic        operand_valid;
   logic [31:0] operand_count;
   logic [7:0]  data;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  response;
   logic        response_valid;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  sb [$];

   always #5 clk = ~clk;

   spi_operand_fifo dut (
      .clock_in           (clk),
      .reset_in           (rst),
      .opcode_in          (opcode),
      .opcode_valid_in    (opcode_valid),
      .operand_in         (operand),
      .operand_valid_in   (operand_valid),
      .operand_count_in   (operand_count),
      .data_out           (data),
      .data_valid_out     (data_valid),
      .data_ready_in      (data_ready),
      .response_out       (response),
      .response_valid_out (response_valid)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // Consumer side: every accepted pop must match the oldest pushed byte.
   always @(negedge clk) begin
      if (!rst && data_valid && data_ready) begin
         if (sb.size() == 0)
            check("sb_empty_pop", sb.size(), 1);
         else
            check("data", data, sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_begin(input logic [7:0] code);
      opcode       = code;
      opcode_valid = 1'b1;
      tick();
   endtask

   task automatic op_end();
      opcode_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic send(input logic [7:0] b, input bit accept);
      operand       = b;
      operand_valid = 1'b1;
      operand_count = operand_count + 1;
      if (accept)
         sb.push_back(b);
      tick();
   endtask

   task automatic send_end();
      operand_valid = 1'b0;
      tick();
   endtask

   task automatic status(input string tag, input logic [7:0] exp);
      op_begin(8'h45);
      check({tag, "_rv_first"}, response_valid, 0);
      tick();
      check({tag, "_rv"}, response_valid, 1);
      check(tag, response, exp);
      op_end();
      check({tag, "_rv_idle"}, response_valid, 0);
      check({tag, "_resp_idle"}, response, 0);
   endtask

   task automatic drain(input string tag);
      data_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() != 0; i++)
         tick();
      check({tag, "_sb_left"}, sb.size(), 0);
      check({tag, "_dv_end"}, data_valid, 0);
      data_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      opcode        = 8'h00;
      opcode_valid  = 1'b0;
      operand       = 8'h00;
      operand_valid = 1'b0;
      operand_count = 0;
      data_ready    = 1'b0;
      #1;
      check("rst_dv", data_valid, 0);
      check("rst_data", data, 0);
      check("rst_resp", response, 0);
      check("rst_rv", response_valid, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Three operands streamed with the consumer always ready.
      data_ready = 1'b1;
      op_begin(8'h44);
      send(8'hA1, 1);
      check("lat_dv_a1", data_valid, 1);
      check("lat_a1", data, 8'hA1);
      send_end();
      send(8'hB2, 1);
      check("lat_dv_b2", data_valid, 1);
      check("lat_b2", data, 8'hB2);
      send_end();
      send(8'hC3, 1);
      check("lat_dv_c3", data_valid, 1);
      check("lat_c3", data, 8'hC3);
      send_end();
      op_end();
      check("seq_sb_left", sb.size(), 0);
      check("seq_dv_end", data_valid, 0);
      data_ready = 1'b0;
      status("st_empty", 8'h00);

      // Overfill: 16 accepted, 2 dropped.
      op_begin(8'h44);
      for (int i = 0; i < 18; i++) begin
         send(8'(8'h10 + i), i < 16);
         send_end();
      end
      op_end();
      status("st_ovf", 8'h90);
      drain("ovf");
      status("st_ovf_drained", 8'h80);

      // Five bytes then flush clears everything including overflow.
      op_begin(8'h44);
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h50 + i), 1);
         send_end();
      end
      op_end();
      status("st_five", 8'h85);
      op_begin(8'h46);
      tick();
      check("flush_dv", data_valid, 0);
      sb.delete();
      op_end();
      status("st_flushed", 8'h00);

      // Full FIFO: push and pop together keep level at DEPTH.
      op_begin(8'h44);
      for (int i = 0; i < 16; i++) begin
         send(8'(8'h60 + i), 1);
         send_end();
      end
      data_ready = 1'b1;
      send(8'h7F, 1);
      data_ready = 1'b0;
      send_end();
      op_end();
      status("st_full_pp", 8'h10);
      drain("full_pp");

      // Reset mid-write discards data and blocks pushes until a new edge.
      op_begin(8'h44);
      for (int i = 0; i < 3; i++) begin
         send(8'(8'h30 + i), 1);
         send_end();
      end
      check("pre_rst_dv", data_valid, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_dv", data_valid, 0);
      sb.delete();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(8'(8'h40 + i), 0);
         send_end();
         check("post_rst_dv", data_valid, 0);
      end
      op_end();
      op_begin(8'h44);
      send(8'hE7, 1);
      check("rearm_dv", data_valid, 1);
      check("rearm_data", data, 8'hE7);
      send_end();
      op_end();
      drain("rearm");

      // Unknown opcode: operands ignored, no response.
      op_begin(8'h10);
      for (int i = 0; i < 3; i++) begin
         send(8'(8'h20 + i), 0);
         check("unk_dv", data_valid, 0);
         check("unk_rv", response_valid, 0);
         send_end();
      end
      op_end();
      status("st_unknown", 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
